// File: rtl/param_issue_stage.sv
// Issue stage: latches scheduled ops (S0), confirms issue, applies recovery flush and replay mux,
// and drives a registered output latch (S1). Optional perf counters behind ISSUE_STAGE_PERF_CNT_EN.
module param_issue_stage #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned IQ_PTR_W    = 4,
    parameter int unsigned AL_PTR_W    = 6,
    parameter int unsigned PAYLOAD_W   = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall_i,
    input  logic                             clear_i,
    input  logic [ISSUE_WIDTH-1:0]           in_valid_i,
    input  logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  in_iq_ptr_i,
    input  logic [ISSUE_WIDTH*AL_PTR_W-1:0]  in_al_ptr_i,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] in_payload_i,
    input  logic                             replay_i,
    input  logic [ISSUE_WIDTH-1:0]           replay_valid_i,
    input  logic [ISSUE_WIDTH*AL_PTR_W-1:0]  replay_al_ptr_i,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] replay_payload_i,
    input  logic                             recovery_i,
    input  logic [AL_PTR_W-1:0]              flush_head_i,
    input  logic [AL_PTR_W-1:0]              flush_tail_i,
    input  logic                             flush_all_i,
    output logic [ISSUE_WIDTH-1:0]           issue_o,
    output logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  issue_ptr_o,
    output logic [ISSUE_WIDTH-1:0]           out_valid_o,
    output logic [ISSUE_WIDTH*AL_PTR_W-1:0]  out_al_ptr_o,
`ifdef ISSUE_STAGE_PERF_CNT_EN
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_payload_o,
    output logic [31:0]                      perf_issue_cnt_o,
    output logic [31:0]                      perf_flush_cnt_o
`else
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_payload_o
`endif
);

    // Flush range is [head, tail) on a circular pointer space; head==tail means empty.
    function automatic logic flush_hit(input logic                rec,
                                       input logic                all,
                                       input logic [AL_PTR_W-1:0] head,
                                       input logic [AL_PTR_W-1:0] tail,
                                       input logic [AL_PTR_W-1:0] p);
        logic hit;
        hit = 1'b0;
        if (rec) begin
            if (all) begin
                hit = 1'b1;
            end else if (head < tail) begin
                hit = (p >= head) && (p < tail);
            end else if (head > tail) begin
                hit = (p >= head) || (p < tail);
            end
        end
        return hit;
    endfunction

    logic [ISSUE_WIDTH-1:0]           s0_valid_q;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  s0_iq_ptr_q;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  s0_al_ptr_q;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] s0_payload_q;

    logic [ISSUE_WIDTH-1:0]           s1_valid_q;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  s1_al_ptr_q;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] s1_payload_q;

    logic [ISSUE_WIDTH-1:0]           sel_valid;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  sel_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] sel_payload;
    logic [ISSUE_WIDTH-1:0]           sel_flush;
    logic [ISSUE_WIDTH-1:0]           s0_flush;
    logic [ISSUE_WIDTH-1:0]           s1_flush;

    always_comb begin
        sel_valid   = '0;
        sel_al_ptr  = '0;
        sel_payload = '0;
        sel_flush   = '0;
        s0_flush    = '0;
        s1_flush    = '0;
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            // Replay takes the lane even when the stage is stalled.
            if (replay_i) begin
                sel_valid[i]                         = replay_valid_i[i];
                sel_al_ptr[i*AL_PTR_W +: AL_PTR_W]   = replay_al_ptr_i[i*AL_PTR_W +: AL_PTR_W];
                sel_payload[i*PAYLOAD_W +: PAYLOAD_W] = replay_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
            end else begin
                sel_valid[i]                         = s0_valid_q[i] && !stall_i;
                sel_al_ptr[i*AL_PTR_W +: AL_PTR_W]   = s0_al_ptr_q[i*AL_PTR_W +: AL_PTR_W];
                sel_payload[i*PAYLOAD_W +: PAYLOAD_W] = s0_payload_q[i*PAYLOAD_W +: PAYLOAD_W];
            end
            sel_flush[i] = flush_hit(recovery_i, flush_all_i, flush_head_i, flush_tail_i,
                                     sel_al_ptr[i*AL_PTR_W +: AL_PTR_W]);
            s0_flush[i]  = flush_hit(recovery_i, flush_all_i, flush_head_i, flush_tail_i,
                                     s0_al_ptr_q[i*AL_PTR_W +: AL_PTR_W]);
            s1_flush[i]  = flush_hit(recovery_i, flush_all_i, flush_head_i, flush_tail_i,
                                     s1_al_ptr_q[i*AL_PTR_W +: AL_PTR_W]);
        end
    end

    // Gated by rst so a replay presented during reset is never confirmed.
    assign issue_o     = (rst || clear_i) ? '0 : (sel_valid & ~sel_flush);
    assign issue_ptr_o = s0_iq_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q   <= '0;
            s0_iq_ptr_q  <= '0;
            s0_al_ptr_q  <= '0;
            s0_payload_q <= '0;
        end else if (!stall_i) begin
            s0_valid_q   <= in_valid_i;
            s0_iq_ptr_q  <= in_iq_ptr_i;
            s0_al_ptr_q  <= in_al_ptr_i;
            s0_payload_q <= in_payload_i;
        end else begin
            s0_valid_q   <= s0_valid_q & ~s0_flush;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= '0;
            s1_al_ptr_q  <= '0;
            s1_payload_q <= '0;
        end else if (stall_i && !replay_i) begin
            s1_valid_q   <= s1_valid_q & ~s1_flush;
        end else begin
            s1_valid_q   <= sel_valid & ~sel_flush & {ISSUE_WIDTH{!clear_i}};
            s1_al_ptr_q  <= sel_al_ptr;
            s1_payload_q <= sel_payload;
        end
    end

    assign out_valid_o   = s1_valid_q;
    assign out_al_ptr_o  = s1_al_ptr_q;
    assign out_payload_o = s1_payload_q;

`ifdef ISSUE_STAGE_PERF_CNT_EN
    logic [31:0] issue_inc;
    logic [31:0] flush_inc;
    logic [31:0] perf_issue_q;
    logic [31:0] perf_flush_q;

    always_comb begin
        issue_inc = '0;
        flush_inc = '0;
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            issue_inc = issue_inc + 32'(issue_o[i]);
            flush_inc = flush_inc + 32'(sel_valid[i] && sel_flush[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_q + issue_inc;
            perf_flush_q <= perf_flush_q + flush_inc;
        end
    end

    assign perf_issue_cnt_o = perf_issue_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_param_issue_stage.sv
// Bench for param_issue_stage: directed scenarios plus randomized traffic against a
// cycle-level reference model using modular-distance flush ranges.
module tb_param_issue_stage;

    localparam int unsigned W   = 2;
    localparam int unsigned IQW = 4;
    localparam int unsigned ALW = 6;
    localparam int unsigned PW  = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall, clear, replay, recovery, flush_all;
    logic [W-1:0]       in_valid, replay_valid;
    logic [W*IQW-1:0]   in_iq;
    logic [W*ALW-1:0]   in_al, replay_al;
    logic [W*PW-1:0]    in_pl, replay_pl;
    logic [ALW-1:0]     flush_head, flush_tail;
    logic [W-1:0]       issue, out_valid;
    logic [W*IQW-1:0]   issue_ptr;
    logic [W*ALW-1:0]   out_al;
    logic [W*PW-1:0]    out_pl;
`ifdef ISSUE_STAGE_PERF_CNT_EN
    logic [31:0]        perf_issue, perf_flush;
    logic [31:0]        m_pi, m_pf;
`endif

    always #5 clk = ~clk;

    param_issue_stage #(
        .ISSUE_WIDTH(W), .IQ_PTR_W(IQW), .AL_PTR_W(ALW), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .clear_i(clear),
        .in_valid_i(in_valid), .in_iq_ptr_i(in_iq), .in_al_ptr_i(in_al), .in_payload_i(in_pl),
        .replay_i(replay), .replay_valid_i(replay_valid), .replay_al_ptr_i(replay_al),
        .replay_payload_i(replay_pl), .recovery_i(recovery), .flush_head_i(flush_head),
        .flush_tail_i(flush_tail), .flush_all_i(flush_all), .issue_o(issue),
        .issue_ptr_o(issue_ptr), .out_valid_o(out_valid), .out_al_ptr_o(out_al),
`ifdef ISSUE_STAGE_PERF_CNT_EN
        .out_payload_o(out_pl), .perf_issue_cnt_o(perf_issue), .perf_flush_cnt_o(perf_flush)
`else
        .out_payload_o(out_pl)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected pipeline contents: what sits in the latch stage and the output stage.
    logic           m0_v  [W];
    logic [IQW-1:0] m0_iq [W];
    logic [ALW-1:0] m0_al [W];
    logic [PW-1:0]  m0_pl [W];
    logic           m1_v  [W];
    logic [ALW-1:0] m1_al [W];
    logic [PW-1:0]  m1_pl [W];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // p is killed when its forward distance from head is shorter than the range length.
    function automatic logic killed(input logic [ALW-1:0] p);
        logic [ALW-1:0] dp, dt;
        if (!recovery) return 1'b0;
        if (flush_all) return 1'b1;
        dp = p - flush_head;
        dt = flush_tail - flush_head;
        return dp < dt;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < int'(W); l++) begin
            m0_v[l] = 1'b0; m0_iq[l] = '0; m0_al[l] = '0; m0_pl[l] = '0;
            m1_v[l] = 1'b0; m1_al[l] = '0; m1_pl[l] = '0;
        end
`ifdef ISSUE_STAGE_PERF_CNT_EN
        m_pi = '0; m_pf = '0;
`endif
    endtask

    task automatic idle();
        stall = 1'b0; clear = 1'b0; replay = 1'b0; recovery = 1'b0; flush_all = 1'b0;
        flush_head = '0; flush_tail = '0; in_valid = '0; replay_valid = '0;
    endtask

    task automatic set_lane(input int l, input logic [IQW-1:0] iq, input logic [ALW-1:0] al,
                            input logic [PW-1:0] pl);
        in_valid[l] = 1'b1;
        in_iq[l*IQW +: IQW] = iq;
        in_al[l*ALW +: ALW] = al;
        in_pl[l*PW +: PW]   = pl;
    endtask

    task automatic set_replay(input int l, input logic [ALW-1:0] al, input logic [PW-1:0] pl);
        replay_valid[l] = 1'b1;
        replay_al[l*ALW +: ALW] = al;
        replay_pl[l*PW +: PW]   = pl;
    endtask

    // Called just after a falling edge with inputs applied: check, advance model, wait.
    task automatic cycle();
        logic           s_v [W];
        logic [ALW-1:0] s_al[W];
        logic [PW-1:0]  s_pl[W];
        logic           exp_iss;
        #1;
`ifdef ISSUE_STAGE_PERF_CNT_EN
        check("perf_issue", 64'(perf_issue), 64'(m_pi));
        check("perf_flush", 64'(perf_flush), 64'(m_pf));
`endif
        for (int l = 0; l < int'(W); l++) begin
            s_v[l]  = replay ? replay_valid[l] : (m0_v[l] && !stall);
            s_al[l] = replay ? replay_al[l*ALW +: ALW] : m0_al[l];
            s_pl[l] = replay ? replay_pl[l*PW +: PW] : m0_pl[l];
            exp_iss = !clear && s_v[l] && !killed(s_al[l]);
            check($sformatf("issue[%0d]", l), 64'(issue[l]), 64'(exp_iss));
            check($sformatf("issue_ptr[%0d]", l), 64'(issue_ptr[l*IQW +: IQW]), 64'(m0_iq[l]));
            check($sformatf("out_valid[%0d]", l), 64'(out_valid[l]), 64'(m1_v[l]));
            check($sformatf("out_al[%0d]", l), 64'(out_al[l*ALW +: ALW]), 64'(m1_al[l]));
            check($sformatf("out_pl[%0d]", l), out_pl[l*PW +: PW], m1_pl[l]);
`ifdef ISSUE_STAGE_PERF_CNT_EN
            m_pi = m_pi + 32'(exp_iss);
            m_pf = m_pf + 32'(s_v[l] && killed(s_al[l]));
`endif
            if (stall && !replay) begin
                m1_v[l] = m1_v[l] && !killed(m1_al[l]);
            end else begin
                m1_v[l]  = exp_iss;
                m1_al[l] = s_al[l];
                m1_pl[l] = s_pl[l];
            end
            if (!stall) begin
                m0_v[l]  = in_valid[l];
                m0_iq[l] = in_iq[l*IQW +: IQW];
                m0_al[l] = in_al[l*ALW +: ALW];
                m0_pl[l] = in_pl[l*PW +: PW];
            end else begin
                m0_v[l] = m0_v[l] && !killed(m0_al[l]);
            end
        end
        @(negedge clk);
    endtask

    // Reset must clear outputs asynchronously, even with a live replay presented.
    task automatic reset_pulse();
        idle();
        replay = 1'b1; replay_valid = '1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_issue", 64'(issue), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_iq = '0; in_al = '0; in_pl = '0; replay_al = '0; replay_pl = '0;
        idle();
        model_reset();
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_issue", 64'(issue), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic two-lane flow.
        idle(); set_lane(0, 4'd3, 6'd5, 64'hA0A0); set_lane(1, 4'd7, 6'd6, 64'hB1B1); cycle();
        idle(); #1;
        check("basic_issue", 64'(issue), 64'(2'b11));
        check("basic_ptr", 64'(issue_ptr), 64'({4'd7, 4'd3}));
        cycle();
        idle(); #1;
        check("basic_out_valid", 64'(out_valid), 64'(2'b11));
        check("basic_pl0", out_pl[63:0], 64'hA0A0);
        check("basic_pl1", out_pl[127:64], 64'hB1B1);
        cycle();

        // Stalled ops, recovery kills only the one in range.
        idle(); set_lane(0, 4'd1, 6'd5, 64'h55); set_lane(1, 4'd2, 6'd9, 64'h99); cycle();
        idle(); stall = 1'b1; cycle();
        idle(); stall = 1'b1; recovery = 1'b1; flush_head = 6'd4; flush_tail = 6'd8; cycle();
        idle(); stall = 1'b1; cycle();
        idle(); #1;
        check("stall_rec_issue", 64'(issue), 64'(2'b10));
        cycle();

        // Wrap-around range.
        idle(); set_lane(0, 4'd4, 6'd62, 64'h62); set_lane(1, 4'd5, 6'd1, 64'h01); cycle();
        idle(); recovery = 1'b1; flush_head = 6'd60; flush_tail = 6'd2; #1;
        check("wrap_killed", 64'(issue), 64'(2'b00));
        cycle();
        idle(); set_lane(0, 4'd6, 6'd2, 64'h02); set_lane(1, 4'd8, 6'd59, 64'h59); cycle();
        idle(); recovery = 1'b1; flush_head = 6'd60; flush_tail = 6'd2; #1;
        check("wrap_kept", 64'(issue), 64'(2'b11));
        cycle();

        // Replay during stall leaves S0 intact.
        idle(); set_lane(0, 4'd9, 6'd30, 64'h30); set_lane(1, 4'd10, 6'd31, 64'h31); cycle();
        idle(); stall = 1'b1; replay = 1'b1; set_replay(0, 6'd10, 64'hC0FFEE); #1;
        check("replay_issue", 64'(issue), 64'(2'b01));
        cycle();
        idle(); stall = 1'b1; #1;
        check("replay_out_valid", 64'(out_valid), 64'(2'b01));
        check("replay_out_pl", out_pl[63:0], 64'hC0FFEE);
        cycle();
        idle(); #1;
        check("replay_s0_kept", 64'(issue), 64'(2'b11));
        cycle();

        // Clear beats replay.
        idle(); replay = 1'b1; set_replay(0, 6'd11, 64'h11); set_replay(1, 6'd12, 64'h12);
        clear = 1'b1; #1;
        check("clear_issue", 64'(issue), 64'(2'b00));
        cycle();
        idle(); #1;
        check("clear_out_valid", 64'(out_valid), 64'(2'b00));
        cycle();

`ifdef ISSUE_STAGE_PERF_CNT_EN
        reset_pulse();
        for (int k = 0; k < 10; k++) begin
            idle(); set_lane(0, 4'd0, 6'd20, 64'(k)); set_lane(1, 4'd1, 6'd21, 64'(k));
            if (k == 5) begin
                recovery = 1'b1; flush_head = 6'd20; flush_tail = 6'd21;
            end
            cycle();
        end
        idle(); cycle();
        #1;
        check("perf_issue_19", 64'(perf_issue), 64'(19));
        check("perf_flush_1", 64'(perf_flush), 64'(1));
`endif

        // Randomized traffic with a reset pulse in the middle.
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) reset_pulse();
            stall        = ($urandom_range(0, 9) < 3);
            replay       = ($urandom_range(0, 9) < 2);
            clear        = ($urandom_range(0, 19) == 0);
            recovery     = ($urandom_range(0, 3) == 0);
            flush_all    = recovery && ($urandom_range(0, 4) == 0);
            flush_head   = ALW'($urandom);
            flush_tail   = ALW'($urandom);
            in_valid     = W'($urandom);
            replay_valid = W'($urandom);
            in_iq        = (W*IQW)'($urandom);
            in_al        = (W*ALW)'($urandom);
            replay_al    = (W*ALW)'($urandom);
            in_pl        = {$urandom, $urandom, $urandom, $urandom};
            replay_pl    = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
